// File: rtl/control_sequencer.sv
// Instruction control sequencer: accepts an instruction word, decodes its opcode
// into a 2-bit control code and holds it with the register field for EXEC_CYC cycles.
module control_sequencer #(
    parameter int INST_W   = 8,
    parameter int OP_W     = 3,
    parameter int OP_BASE  = 2,
    parameter int EXEC_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [INST_W-1:0] instruction,
    output logic [1:0]        con_inst,
    output logic [INST_W-OP_W-1:0] con_reg,
    output logic              con_valid,
    output logic              illegal,
    output logic              done
);

    localparam int REG_W      = INST_W - OP_W;
    localparam int CNT_W      = (EXEC_CYC > 1) ? $clog2(EXEC_CYC) : 1;
    localparam int OP_HI_I    = OP_BASE + 3;
    localparam int CNT_INIT_I = EXEC_CYC - 1;

    // One extra bit so OP_BASE+3 cannot wrap when it sits at the top of the opcode range.
    localparam logic [OP_W:0]    OP_LO    = OP_BASE[OP_W:0];
    localparam logic [OP_W:0]    OP_HI    = OP_HI_I[OP_W:0];
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_INIT_I[CNT_W-1:0];

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC
    } state_t;

    state_t            state;
    logic [INST_W-1:0] inst_q;
    logic [CNT_W-1:0]  count;

    logic [OP_W:0] op_ext;
    logic          op_legal;
    logic [1:0]    op_code;

    assign op_ext   = {1'b0, inst_q[INST_W-1 -: OP_W]};
    assign op_legal = (op_ext >= OP_LO) && (op_ext <= OP_HI);
    assign op_code  = op_ext[1:0] - OP_LO[1:0];

    assign inst_ready = (state == IDLE);
    assign con_valid  = (state == EXEC);
    assign done       = (state == EXEC) && (count == '0);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            inst_q   <= '0;
            count    <= '0;
            con_inst <= 2'b00;
            con_reg  <= '0;
            illegal  <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_valid) begin
                        inst_q <= instruction;
                        state  <= DECODE;
                    end
                end
                DECODE: begin
                    if (op_legal) begin
                        con_inst <= op_code;
                        con_reg  <= inst_q[REG_W-1:0];
                        count    <= CNT_INIT;
                        state    <= EXEC;
                    end else begin
                        illegal <= 1'b1;
                        state   <= IDLE;
                    end
                end
                EXEC: begin
                    // Exit at zero rather than letting the counter wrap.
                    if (count == '0) begin
                        state <= IDLE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
